// File: rtl/rv_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_fetch_pkg
// Purpose  : Shared fetch constants and the fetch packet type used by decode.
// Revision : 1.0
// ============================================================================
package rv_fetch_pkg;

  localparam int unsigned XLEN        = 32;
  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_pkt_t;

  // Word-aligns a byte address; the low two bits of a target are not meaningful.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(INSTR_BYTES - 1);
  endfunction

endpackage : rv_fetch_pkg
`default_nettype wire

// File: rtl/fetch_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_skid_buffer
// Purpose  : One-entry holding register for a fetch response decode refused.
// Revision : 1.0
// ============================================================================
module fetch_skid_buffer
  import rv_fetch_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       flush_i,
  input  logic       ready_i,
  input  logic       resp_valid_i,
  input  fetch_pkt_t resp_pkt_i,
  output logic       skid_valid_o,
  output logic       out_valid_o,
  output fetch_pkt_t out_pkt_o
);

  logic       skid_valid_q, skid_valid_d;
  fetch_pkt_t skid_pkt_q,   skid_pkt_d;

  always_comb begin
    skid_valid_d = skid_valid_q;
    skid_pkt_d   = skid_pkt_q;
    if (flush_i) begin
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (ready_i) begin
        skid_valid_d = 1'b0;
      end
    end else if (resp_valid_i && !ready_i) begin
      // The memory word is only present for one cycle, so park it here.
      skid_valid_d = 1'b1;
      skid_pkt_d   = resp_pkt_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skid_valid_q <= 1'b0;
      skid_pkt_q   <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_pkt_q   <= skid_pkt_d;
    end
  end

  assign skid_valid_o = skid_valid_q;
  assign out_valid_o  = !flush_i && (skid_valid_q || resp_valid_i);
  assign out_pkt_o    = skid_valid_q ? skid_pkt_q : resp_pkt_i;

endmodule : fetch_skid_buffer
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : PC owner and instruction-memory driver with valid/ready to decode.
// Revision : 1.0
// ============================================================================
module fetch_unit #(
  parameter int unsigned DWIDTH    = 32,
  parameter logic [31:0] RESET_PC  = rv_fetch_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = rv_fetch_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              reset,
  output logic [DWIDTH-1:0] imemAddress,
  output logic              imemEnable,
  input  logic [DWIDTH-1:0] imemInstruction,
  input  logic              redirectIn,
  input  logic [DWIDTH-1:0] redirectPc,
  output logic [DWIDTH-1:0] instructionOut,
  output logic [DWIDTH-1:0] pcOut,
  output logic              validOut,
  input  logic              readyIn
);

  import rv_fetch_pkg::*;

  logic [DWIDTH-1:0] pc_q,     pc_d;
  logic              req_q,    req_d;
  logic [DWIDTH-1:0] reqPc_q,  reqPc_d;

  logic              respValid;
  logic              skidValid;
  logic              bufValid;
  fetch_pkt_t        respPkt;
  fetch_pkt_t        bufPkt;

  assign respValid = req_q;
  assign respPkt   = '{instr: imemInstruction, pc: reqPc_q};

  always_comb begin
    imemEnable  = 1'b0;
    imemAddress = pc_q;
    pc_d        = pc_q;
    req_d       = 1'b0;
    reqPc_d     = reqPc_q;
    if (reset) begin
      if (redirectIn) begin
        imemEnable  = 1'b1;
        imemAddress = align_word(redirectPc);
      end else begin
        // Only fetch when there is somewhere to put the returning word.
        imemEnable  = readyIn || (!skidValid && !respValid);
      end
    end
    if (imemEnable) begin
      req_d   = 1'b1;
      reqPc_d = imemAddress;
      pc_d    = imemAddress + DWIDTH'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      reqPc_q <= '0;
    end else begin
      pc_q    <= pc_d;
      req_q   <= req_d;
      reqPc_q <= reqPc_d;
    end
  end

  fetch_skid_buffer u_skid (
    .clk          (clk),
    .reset        (reset),
    .flush_i      (redirectIn),
    .ready_i      (readyIn),
    .resp_valid_i (respValid),
    .resp_pkt_i   (respPkt),
    .skid_valid_o (skidValid),
    .out_valid_o  (bufValid),
    .out_pkt_o    (bufPkt)
  );

  assign validOut       = bufValid;
  assign instructionOut = bufValid ? bufPkt.instr : NOP_INSTR;
  assign pcOut          = bufValid ? bufPkt.pc    : '0;

endmodule : fetch_unit
`default_nettype wire
